// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
//
// Purpose
//   Oversampling UART receiver. A falling edge on the idle-high serial line
//   starts a frame. The start bit is re-checked at its midpoint to reject
//   glitches. Data, optional parity and stop bits are then sampled once per
//   bit period, at the centre of each bit. A completed word is delivered
//   together with its error flags, even if the frame contains errors.
//
// Parameters
//   DATA_BITS    data bits per frame (5..9)
//   OVERSAMPLE   clk_br cycles per bit (even, 8..254)
//   PARITY_MODE  0 = none, 1 = even, 2 = odd
//   STOP_BITS    1 or 2
//
// Ports
//   clk_br      in   single clock; all state changes on its rising edge
//   rst_n       in   asynchronous active-low reset
//   rx          in   serial line, idles high
//   read        in   consumer acknowledge; clears ready
//   data        out  last received word, LSB = first bit on the line
//   ready       out  a word is held in data and has not been read yet
//   parity_err  out  parity mismatch on the last delivered word
//   frame_err   out  a stop bit was sampled low on the last delivered word
//   overrun     out  a word was delivered while ready was still high
//   busy        out  receiver is in any state other than IDLE
//
// Configuration macro
//   UART_RX_SYNC_EN  when defined, rx passes through a two-flop synchronizer
//                    (reset value 1) before use, adding 2 cycles of latency.
//                    When undefined, rx is used directly.
// -----------------------------------------------------------------------------
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 20,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk_br,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 read,
  output logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Sample-counter values at which the line is examined: the middle of the
  // start bit, and the middle of every subsequent bit (counted from the
  // previous sample point, one full bit period later).
  localparam logic [7:0] CNT_HALF_LAST = 8'(OVERSAMPLE / 2 - 1);
  localparam logic [7:0] CNT_BIT_LAST  = 8'(OVERSAMPLE - 1);
  localparam logic [3:0] IDX_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] IDX_STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic       PARITY_ODD    = (PARITY_MODE == 2);
  localparam bit         PARITY_EN     = (PARITY_MODE != 0);

  // ---------------------------------------------------------------------------
  // Line input conditioning
  // ---------------------------------------------------------------------------
  logic w_rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;

  // Reset to the idle level so a released reset never looks like a start bit
  // unless the line really is low.
  always_ff @(posedge clk_br or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  assign w_rx_s = r_sync[1];
`else
  assign w_rx_s = rx;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               r_state;
  logic [7:0]           r_cnt;
  logic [3:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_pend;  // parity mismatch seen in this frame
  logic                 r_frm_pend;  // low stop sample seen in this frame

  logic [DATA_BITS-1:0] r_data;
  logic                 r_ready;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overrun;

  state_t               w_state_nx;
  logic [7:0]           w_cnt_nx;
  logic [3:0]           w_idx_nx;
  logic [DATA_BITS-1:0] w_shift_nx;
  logic                 w_par_pend_nx;
  logic                 w_frm_pend_nx;
  logic                 w_deliver;

  logic [DATA_BITS-1:0] w_data_nx;
  logic                 w_ready_nx;
  logic                 w_parity_err_nx;
  logic                 w_frame_err_nx;
  logic                 w_overrun_nx;

  logic                 w_bit_tick;
  logic                 w_par_expect;

  assign w_bit_tick   = (r_cnt == CNT_BIT_LAST);
  // Expected line level of the parity bit for the word collected so far.
  assign w_par_expect = (^r_shift) ^ PARITY_ODD;

  // ---------------------------------------------------------------------------
  // Next-state logic for the frame FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case statement; a path
    // that leaves one unassigned would infer a latch.
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_idx_nx      = r_idx;
    w_shift_nx    = r_shift;
    w_par_pend_nx = r_par_pend;
    w_frm_pend_nx = r_frm_pend;
    w_deliver     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nx = S_START;
          w_cnt_nx   = '0;
        end
      end

      S_START: begin
        if (r_cnt == CNT_HALF_LAST) begin
          w_cnt_nx = '0;
          if (w_rx_s) begin
            // Line went back high before mid-start: a glitch, not a frame.
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx    = S_DATA;
            w_idx_nx      = '0;
            w_par_pend_nx = 1'b0;
            w_frm_pend_nx = 1'b0;
          end
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end

      S_DATA: begin
        if (w_bit_tick) begin
          w_cnt_nx   = '0;
          // Shift in from the top so the first received bit ends in bit 0.
          w_shift_nx = {w_rx_s, r_shift[DATA_BITS-1:1]};
          if (r_idx == IDX_DATA_LAST) begin
            w_idx_nx   = '0;
            w_state_nx = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            w_idx_nx = r_idx + 4'd1;
          end
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end

      S_PARITY: begin
        if (w_bit_tick) begin
          w_cnt_nx      = '0;
          w_par_pend_nx = (w_rx_s != w_par_expect);
          w_idx_nx      = '0;
          w_state_nx    = S_STOP;
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end

      S_STOP: begin
        if (w_bit_tick) begin
          w_cnt_nx = '0;
          if (!w_rx_s) begin
            w_frm_pend_nx = 1'b1;
          end
          if (r_idx == IDX_STOP_LAST) begin
            w_deliver  = 1'b1;
            w_idx_nx   = '0;
            w_state_nx = S_IDLE;
          end else begin
            w_idx_nx = r_idx + 4'd1;
          end
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end

      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
        w_idx_nx   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Delivery / consumer handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    w_data_nx       = r_data;
    w_ready_nx      = r_ready;
    w_parity_err_nx = r_parity_err;
    w_frame_err_nx  = r_frame_err;
    w_overrun_nx    = r_overrun;

    // A read only counts while a word is actually pending.
    if (read && r_ready) begin
      w_ready_nx   = 1'b0;
      w_overrun_nx = 1'b0;
    end

    // Delivery takes priority over a simultaneous read: the new word stays
    // pending. Overrun only flags a word that was never acknowledged.
    if (w_deliver) begin
      w_data_nx       = r_shift;
      w_ready_nx      = 1'b1;
      w_parity_err_nx = r_par_pend;
      w_frame_err_nx  = r_frm_pend | ~w_rx_s;
      if (r_ready && !read) begin
        w_overrun_nx = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_br or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_par_pend   <= 1'b0;
      r_frm_pend   <= 1'b0;
      r_data       <= '0;
      r_ready      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values from before this edge, independent of statement order.
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_idx        <= w_idx_nx;
      r_shift      <= w_shift_nx;
      r_par_pend   <= w_par_pend_nx;
      r_frm_pend   <= w_frm_pend_nx;
      r_data       <= w_data_nx;
      r_ready      <= w_ready_nx;
      r_parity_err <= w_parity_err_nx;
      r_frame_err  <= w_frame_err_nx;
      r_overrun    <= w_overrun_nx;
    end
  end

  assign data       = r_data;
  assign ready      = r_ready;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
//
// Three receivers share one serial line, one read strobe and one reset:
//   inst 0: no parity, 1 stop bit
//   inst 1: even parity, 1 stop bit
//   inst 2: odd parity, 2 stop bits
// A behavioural model decodes the line from sample-time arithmetic (start
// detect time plus half a bit, then whole bit periods) and predicts every
// output of every receiver; the outputs are compared once per cycle.
// Directed frames pin the model with hand-derived values, then a randomized
// phase mixes frames, bad parity, bad stop bits, glitches and random reads.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

  localparam int OS = 20;
  localparam int DB = 8;
  localparam int NI = 3;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk_br = 1'b0;
  logic rst_n  = 1'b0;
  logic rx     = 1'b1;
  logic read   = 1'b0;

  logic [DB-1:0] d_data [NI];
  logic [NI-1:0] d_ready, d_pe, d_fe, d_ovr, d_busy;

  always #5 clk_br = ~clk_br;

  uart_rx_param #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
    .clk_br(clk_br), .rst_n(rst_n), .rx(rx), .read(read),
    .data(d_data[0]), .ready(d_ready[0]), .parity_err(d_pe[0]),
    .frame_err(d_fe[0]), .overrun(d_ovr[0]), .busy(d_busy[0]));

  uart_rx_param #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_MODE(1), .STOP_BITS(1)) u_dut1 (
    .clk_br(clk_br), .rst_n(rst_n), .rx(rx), .read(read),
    .data(d_data[1]), .ready(d_ready[1]), .parity_err(d_pe[1]),
    .frame_err(d_fe[1]), .overrun(d_ovr[1]), .busy(d_busy[1]));

  uart_rx_param #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_MODE(2), .STOP_BITS(2)) u_dut2 (
    .clk_br(clk_br), .rst_n(rst_n), .rx(rx), .read(read),
    .data(d_data[2]), .ready(d_ready[2]), .parity_err(d_pe[2]),
    .frame_err(d_fe[2]), .overrun(d_ovr[2]), .busy(d_busy[2]));

  function automatic int pm_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 2);
  endfunction

  function automatic int sb_of(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoring
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] t=%0t got=0x%0h expected=0x%0h", name, idx, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit            m_act  [NI];
  int            m_rel  [NI];   // edges since start detect
  logic [DB-1:0] m_bits [NI];
  bit            m_pe   [NI];
  bit            m_fe   [NI];
  logic [1:0]    m_sync = 2'b11;

  logic [DB-1:0] e_data  [NI];
  bit            e_ready [NI];
  bit            e_pe    [NI];
  bit            e_fe    [NI];
  bit            e_ovr   [NI];
  bit            e_busy  [NI];

  always @(posedge clk_br or negedge rst_n) begin
    if (!rst_n) begin
      m_sync = 2'b11;
      for (int i = 0; i < NI; i++) begin
        m_act[i] = 0; m_rel[i] = 0; m_bits[i] = '0; m_pe[i] = 0; m_fe[i] = 0;
        e_data[i] = '0; e_ready[i] = 0; e_pe[i] = 0; e_fe[i] = 0;
        e_ovr[i] = 0; e_busy[i] = 0;
      end
    end else begin
      logic rxs;
      rxs = (SYNC_LAT != 0) ? m_sync[1] : rx;
      m_sync = {m_sync[0], rx};
      for (int i = 0; i < NI; i++) begin
        bit dlv;
        int h, k, np;
        dlv = 0;
        h   = OS / 2;
        np  = (pm_of(i) != 0) ? 1 : 0;
        if (!m_act[i]) begin
          if (!rxs) begin
            m_act[i] = 1; m_rel[i] = 0; m_pe[i] = 0; m_fe[i] = 0;
          end
        end else begin
          m_rel[i]++;
          if (m_rel[i] == h) begin
            if (rxs) m_act[i] = 0;
          end else if (m_rel[i] > h && ((m_rel[i] - h) % OS) == 0) begin
            k = (m_rel[i] - h) / OS - 1;   // 0-based bit after the start bit
            if (k < DB) begin
              m_bits[i][k] = rxs;
            end else if (k < DB + np) begin
              m_pe[i] = (rxs != ((^m_bits[i]) ^ (pm_of(i) == 2)));
            end else begin
              if (!rxs) m_fe[i] = 1;
              if (k == DB + np + sb_of(i) - 1) begin
                dlv = 1;
                m_act[i] = 0;
              end
            end
          end
        end
        if (dlv) begin
          if (e_ready[i] && !read) e_ovr[i] = 1;
          else if (e_ready[i] && read) e_ovr[i] = 0;
          e_ready[i] = 1; e_data[i] = m_bits[i]; e_pe[i] = m_pe[i]; e_fe[i] = m_fe[i];
        end else if (read && e_ready[i]) begin
          e_ready[i] = 0; e_ovr[i] = 0;
        end
        e_busy[i] = m_act[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare and ready-rise monitor
  // ---------------------------------------------------------------------------
  int cyc = 0;
  bit cmp_en = 0;
  int rise_cyc [NI];
  logic [NI-1:0] ready_q = '0;

  always @(posedge clk_br) begin
    cyc++;
    #1;
    if (cmp_en) begin
      for (int i = 0; i < NI; i++) begin
        check("data",       i, 32'(d_data[i]), 32'(e_data[i]));
        check("ready",      i, 32'(d_ready[i]), 32'(e_ready[i]));
        check("parity_err", i, 32'(d_pe[i]),   32'(e_pe[i]));
        check("frame_err",  i, 32'(d_fe[i]),   32'(e_fe[i]));
        check("overrun",    i, 32'(d_ovr[i]),  32'(e_ovr[i]));
        check("busy",       i, 32'(d_busy[i]), 32'(e_busy[i]));
      end
    end
    for (int i = 0; i < NI; i++) begin
      if (d_ready[i] === 1'b1 && ready_q[i] !== 1'b1) rise_cyc[i] = cyc;
    end
    ready_q = d_ready;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  bit rnd_mode = 0;
  int t_drive  = 0;

  task automatic drive_bit(input logic b, input int n);
    repeat (n) begin
      @(negedge clk_br);
      rx   = b;
      read = rnd_mode ? ($urandom_range(0, 7) == 0) : 1'b0;
    end
  endtask

  task automatic send_seq(input logic [15:0] seq, input int n);
    for (int i = 0; i < NI; i++) rise_cyc[i] = -1;
    for (int j = 0; j < n; j++) begin
      for (int c = 0; c < OS; c++) begin
        @(negedge clk_br);
        if (j == 0 && c == 0) t_drive = cyc;
        rx   = seq[j];
        read = rnd_mode ? ($urandom_range(0, 7) == 0) : 1'b0;
      end
    end
  endtask

  // start, data LSB-first, optional parity, one stop bit
  task automatic send_frame(input logic [7:0] d, input bit has_par, input bit par,
                            input bit stop);
    logic [15:0] seq;
    int n;
    seq = '0;
    seq[8:1] = d;
    if (has_par) begin
      seq[9]  = par;
      seq[10] = stop;
      n = 11;
    end else begin
      seq[9] = stop;
      n = 10;
    end
    send_seq(seq, n);
  endtask

  task automatic read_pulse();
    @(negedge clk_br); read = 1'b1;
    @(negedge clk_br); read = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < NI; i++) begin
      check({name, "_data"},  i, 32'(d_data[i]), 32'h0);
      check({name, "_flags"}, i, 32'({d_ready[i], d_pe[i], d_fe[i], d_ovr[i], d_busy[i]}), 32'h0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit   busy_seen;
    logic [7:0] rd;
    int   gap;

    repeat (3) @(negedge clk_br);
    check_all_zero("reset");
    rst_n = 1'b1;
    cmp_en = 1;
    drive_bit(1'b1, 5);

    // 0xA5, good stop, no parity bit on the line. Counting the first edge
    // after start detection as edge 0, delivery is on edge
    // OS/2 + (1 + 8 data + 1 stop - 1)*OS - 1 = 10 + 180 - 1 = 189.
    send_frame(8'hA5, 0, 0, 1);
    drive_bit(1'b1, 50);
    check("a5_latency", 0, 32'(rise_cyc[0] - t_drive - 2), 32'(189 + SYNC_LAT));
    check("a5_data",    0, 32'(d_data[0]), 32'hA5);
    check("a5_flags",   0, 32'({d_ready[0], d_pe[0], d_fe[0], d_ovr[0]}), 32'b1000);
    check("a5_model",   0, 32'(e_data[0]), 32'hA5);
    read_pulse();

    // 0x55 (four ones, even parity bit should be 0) sent with parity bit 1.
    send_frame(8'h55, 1, 1, 1);
    drive_bit(1'b1, 50);
    check("par1_latency", 1, 32'(rise_cyc[1] - t_drive - 2), 32'(209 + SYNC_LAT));
    check("par1_data",    1, 32'(d_data[1]), 32'h55);
    check("par1_err",     1, 32'(d_pe[1]), 32'h1);
    check("par1_model",   1, 32'(e_pe[1]), 32'h1);
    read_pulse();
    send_frame(8'h55, 1, 0, 1);
    drive_bit(1'b1, 50);
    check("par0_err",   1, 32'(d_pe[1]), 32'h0);
    check("par0_ready", 1, 32'(d_ready[1]), 32'h1);
    // Odd parity receiver sees bit 0 where it wants 1.
    check("par0_odd",   2, 32'(d_pe[2]), 32'h1);
    read_pulse();

    // Glitch: 5 low cycles then high.
    drive_bit(1'b0, 1);
    @(posedge clk_br); #2;
    busy_seen = (d_busy[0] === 1'b1);
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 30);
    check("glitch_busy_seen", 0, 32'(busy_seen), 32'h1);
    check("glitch_busy_end",  0, 32'(d_busy[0]), 32'h0);
    check("glitch_ready",     0, 32'(d_ready[0]), 32'h0);

    // Two words without a read.
    send_frame(8'h12, 0, 0, 1);
    drive_bit(1'b1, 50);
    send_frame(8'h34, 0, 0, 1);
    drive_bit(1'b1, 50);
    check("ovr_data", 0, 32'(d_data[0]), 32'h34);
    check("ovr_set",  0, 32'(d_ovr[0]), 32'h1);
    read_pulse();
    check("ovr_rd_ready", 0, 32'(d_ready[0]), 32'h0);
    check("ovr_rd_clear", 0, 32'(d_ovr[0]), 32'h0);

    // 0xFF with a low stop bit.
    send_frame(8'hFF, 0, 0, 0);
    drive_bit(1'b1, 50);
    check("fe_data",  0, 32'(d_data[0]), 32'hFF);
    check("fe_flags", 0, 32'({d_ready[0], d_fe[0]}), 32'b11);
    read_pulse();

    // Reset in the middle of a frame, then a clean frame.
    drive_bit(1'b0, OS);
    drive_bit(1'b1, OS);
    drive_bit(1'b0, OS);
    @(negedge clk_br);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clk_br);
    rst_n = 1'b1;
    drive_bit(1'b1, 20);
    send_frame(8'h3C, 0, 0, 1);
    drive_bit(1'b1, 50);
    check("post_rst_data",  0, 32'(d_data[0]), 32'h3C);
    check("post_rst_flags", 0, 32'({d_ready[0], d_fe[0], d_ovr[0]}), 32'b100);
    read_pulse();

    // Randomized traffic, including back-to-back frames and random reads.
    rnd_mode = 1;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        drive_bit(1'b0, $urandom_range(1, 9));
        drive_bit(1'b1, 12);
      end else begin
        rd = 8'($urandom);
        send_frame(rd, 1'($urandom_range(0, 1)),
                   (^rd) ^ ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 7) != 0));
        gap = $urandom_range(0, 30);
        if (gap > 0) drive_bit(1'b1, gap);
      end
    end
    rnd_mode = 0;
    drive_bit(1'b1, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
